// File: rtl/lsu_multi.sv
// Load/store unit: one access per start, request/acknowledge bus handshake with timeout,
// byte-lane placement for stores and lane extraction with sign/zero extension for loads.
module lsu_multi #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic [1:0]        err_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int L  = $clog2(NB);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [31:0] MAX_WAIT_U = MAX_WAIT;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_reg;
    logic          we_reg;
    logic [2:0]    funct3_reg;
    logic [L-1:0]  lane_reg;
    logic [CW-1:0] count_reg;

    logic [1:0]        req_size;
    logic [L-1:0]      req_lane;
    logic [31:0]       req_nbytes;
    logic [ADDR_W-1:0] req_adr;
    logic              req_illegal;
    logic              req_misaligned;
    logic [NB-1:0]     req_be;
    logic [XLEN-1:0]   req_wkeep;
    logic [XLEN-1:0]   req_wdata;

    assign req_size   = funct3[1:0];
    assign req_lane   = addr[L-1:0];
    assign req_nbytes = 32'd1 << req_size;
    assign req_adr    = {addr[ADDR_W-1:L], {L{1'b0}}};

    // funct3[2] (unsigned) is only meaningful for loads narrower than XLEN
    assign req_illegal = ((XLEN == 32) && (req_size == 2'b11))
                      || ((XLEN == 32) && (req_size == 2'b10) && funct3[2])
                      || (we && funct3[2]);

    always_comb begin
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = addr[0];
            2'b10:   req_misaligned = |addr[1:0];
            default: req_misaligned = |addr[2:0];
        endcase
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            localparam logic [31:0] IDX = gi;
            assign req_be[gi] = (IDX >= 32'(req_lane)) && (IDX < 32'(req_lane) + req_nbytes);
            assign req_wkeep[gi*8 +: 8] = (IDX < req_nbytes) ? wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign req_wdata = we ? (req_wkeep << {req_lane, 3'b000}) : '0;

    // Load path: bring the addressed lane down to bit 0, then extend to XLEN.
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_value;
    logic [6:0]      ld_width;
    logic            ld_sign;

    assign ld_shifted = mem_rdata >> {lane_reg, 3'b000};

    always_comb begin
        ld_value = ld_shifted;
        ld_width = 7'(XLEN);
        ld_sign  = 1'b0;
        case (funct3_reg[1:0])
            2'b00: begin
                ld_value = XLEN'(ld_shifted[7:0]);
                ld_width = 7'd8;
                ld_sign  = ld_shifted[7];
            end
            2'b01: begin
                ld_value = XLEN'(ld_shifted[15:0]);
                ld_width = 7'd16;
                ld_sign  = ld_shifted[15];
            end
            2'b10: begin
                ld_value = XLEN'(ld_shifted[31:0]);
                ld_width = 7'd32;
                ld_sign  = ld_shifted[31];
            end
            default: begin
                ld_value = ld_shifted;
                ld_width = 7'(XLEN);
                ld_sign  = 1'b0;
            end
        endcase
        if (!funct3_reg[2] && ld_sign)
            ld_value = ld_value | ({XLEN{1'b1}} << ld_width);
    end

    logic timeout;
    assign timeout = (MAX_WAIT != 0) && ((32'(count_reg) + 32'd1) >= MAX_WAIT_U);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            lane_reg   <= '0;
            count_reg  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            err_code   <= ERR_OK;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        we_reg     <= we;
                        funct3_reg <= funct3;
                        lane_reg   <= req_lane;
                        count_reg  <= '0;
                        busy       <= 1'b1;
                        if (req_illegal || req_misaligned) begin
                            state_reg <= RESP;
                            done      <= 1'b1;
                            rdata     <= '0;
                            err_code  <= req_illegal ? ERR_SIZE : ERR_MISALIGN;
                        end else begin
                            state_reg <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= we;
                            mem_adr   <= req_adr;
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving in the timeout cycle still completes the access.
                    if (mem_ack || timeout) begin
                        state_reg <= RESP;
                        done      <= 1'b1;
                        err_code  <= mem_ack ? ERR_OK : ERR_TIMEOUT;
                        rdata     <= (mem_ack && !we_reg) ? ld_value : '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_adr   <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_multi.sv
// Scoreboard bench for lsu_multi: a 32-bit and a 64-bit instance driven with directed and
// random accesses; expectations come from an arithmetic model of the access rules.
module tb_lsu_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int fin_cnt = 0;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        int          delay;
    } stim_t;

    typedef struct {
        logic [1:0]  err;
        logic [63:0] rdata;
        logic [31:0] adr;
        logic [7:0]  be;
        logic [63:0] wdata;
        bit          we;
        longint      done_cyc;
        int          req_cycles;
    } exp_t;

    task automatic check(input int tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL x%0d %s: got 0x%0h required 0x%0h at t=%0t", tag, name, act, exp, $time);
    endtask

    function automatic stim_t mk(bit we, logic [2:0] f3, logic [31:0] a, logic [63:0] wd,
                                 logic [63:0] rd, int d);
        stim_t s;
        s.we = we; s.f3 = f3; s.addr = a; s.wd = wd; s.rd = rd; s.delay = d;
        return s;
    endfunction

    // Reference: sizes in bytes, lanes as address modulo bus width, masks by arithmetic.
    function automatic exp_t model(stim_t s, int xlen, int max_wait, longint c);
        exp_t        e;
        int          nb;
        int          nbus;
        int          lane;
        logic [63:0] fmask, xmask, field;
        e = '{default: 0};
        nb   = 1 << s.f3[1:0];
        nbus = xlen / 8;
        lane = int'(s.addr % nbus);
        e.we = s.we;
        if ((nb == 8 && xlen == 32) || (nb == 4 && s.f3[2] && xlen == 32) || (s.we && s.f3[2])) begin
            e.err = 2'b10; e.done_cyc = c + 1; return e;
        end
        if ((s.addr % nb) != 0) begin
            e.err = 2'b01; e.done_cyc = c + 1; return e;
        end
        fmask   = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        xmask   = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        e.adr   = s.addr - lane;
        e.be    = 8'(((1 << nb) - 1) << lane);
        e.wdata = s.we ? (((s.wd & fmask) << (8 * lane)) & xmask) : 64'd0;
        if (max_wait != 0 && s.delay >= max_wait) begin
            e.err = 2'b11; e.rdata = 0; e.done_cyc = c + 1 + max_wait; e.req_cycles = max_wait;
        end else begin
            field = (s.rd >> (8 * lane)) & fmask;
            if (!s.f3[2] && field[8 * nb - 1]) field = field | ~fmask;
            e.err = 2'b00;
            e.rdata = s.we ? 64'd0 : (field & xmask);
            e.done_cyc = c + 2 + s.delay;
            e.req_cycles = s.delay + 1;
        end
        return e;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int XW = (gi == 0) ? 32 : 64;
        localparam int MW = (gi == 0) ? 4 : 6;

        logic            reset, start, we, busy, done, mem_req, mem_we, mem_ack;
        logic [2:0]      funct3;
        logic [31:0]     addr, mem_adr;
        logic [XW-1:0]   wdata, rdata, mem_wdata, mem_rdata;
        logic [1:0]      err_code;
        logic [XW/8-1:0] mem_be;
        int              ack_delay = 0;
        int              wait_cnt  = 0;
        int              req_cnt   = 0;
        longint          cyc       = 0;
        bit              prev_done = 1'b0;
        exp_t            sb[$];

        lsu_multi #(.XLEN(XW), .ADDR_W(32), .MAX_WAIT(MW)) dut (
            .clk(clk), .reset(reset), .start(start), .we(we), .funct3(funct3),
            .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
            .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
            .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Bus responder: acks after ack_delay wait cycles, random noise while idle.
        always @(negedge clk) begin
            if (mem_req) begin
                mem_ack = (wait_cnt == ack_delay);
                wait_cnt++;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                wait_cnt = 0;
            end
        end

        // Monitor: bus fields while requesting, result and latency on done.
        always @(negedge clk) begin
            exp_t e;
            if (!busy) req_cnt = 0;
            if (prev_done) check(XW, "busy_after_done", busy, 0);
            if (mem_req) begin
                req_cnt++;
                if (sb.size() != 0) begin
                    check(XW, "mem_adr", mem_adr, sb[0].adr);
                    check(XW, "mem_be", 64'(mem_be), 64'(sb[0].be));
                    check(XW, "mem_wdata", 64'(mem_wdata), sb[0].wdata);
                    check(XW, "mem_we", mem_we, sb[0].we);
                end
            end else if (!reset) begin
                check(XW, "bus_idle", 64'(mem_we) | 64'(mem_be) | 64'(mem_adr) | 64'(mem_wdata), 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check(XW, "unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("x%0d txn: err=%0d rdata=0x%0h req_cycles=%0d", XW, err_code, rdata, req_cnt);
                    check(XW, "err_code", err_code, e.err);
                    check(XW, "rdata", 64'(rdata), e.rdata);
                    check(XW, "done_cycle", cyc, e.done_cyc);
                    check(XW, "req_cycles", req_cnt, e.req_cycles);
                end
            end
            prev_done = done;
        end

        initial begin
            stim_t dir[$];
            stim_t s;
            reset = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0;
            wdata = '0; mem_rdata = '0; ack_delay = 0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check(XW, "rst_busy", busy, 0);
            check(XW, "rst_done", done, 0);
            check(XW, "rst_mem_req", mem_req, 0);
            check(XW, "rst_rdata", 64'(rdata), 0);
            check(XW, "rst_err", err_code, 0);

            // Abort a load in its second bus cycle.
            @(negedge clk);
            start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h300; ack_delay = 1000;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check(XW, "abort_req_before", mem_req, 1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check(XW, "abort_mem_req", mem_req, 0);
            check(XW, "abort_busy", busy, 0);

            dir.push_back(mk(1'b0, 3'b010, 32'h200, 64'h0, 64'h1234_5678_9ABC_DEF0, 1));
            if (XW == 32) begin
                dir.push_back(mk(1'b0, 3'b100, 32'h103, 64'h0, 64'h80AB_CD12, 0));
                dir.push_back(mk(1'b0, 3'b001, 32'h102, 64'h0, 64'h80AB_CD12, 3));
                dir.push_back(mk(1'b1, 3'b000, 32'h101, 64'h5A, 64'h0, 0));
                dir.push_back(mk(1'b0, 3'b010, 32'h102, 64'h0, 64'h0, 0));
                dir.push_back(mk(1'b1, 3'b011, 32'h100, 64'h1, 64'h0, 0));
                dir.push_back(mk(1'b0, 3'b010, 32'h100, 64'h0, 64'hCAFE_F00D, 1000));
                dir.push_back(mk(1'b0, 3'b010, 32'h100, 64'h0, 64'hCAFE_F00D, 3));
            end else begin
                dir.push_back(mk(1'b0, 3'b110, 32'h14, 64'h0, 64'hDEAD_BEEF_0000_0000, 0));
                dir.push_back(mk(1'b1, 3'b011, 32'h28, 64'h0123_4567_89AB_CDEF, 64'h0, 2));
                dir.push_back(mk(1'b0, 3'b011, 32'h2C, 64'h0, 64'h0, 0));
                dir.push_back(mk(1'b0, 3'b000, 32'h17, 64'h0, 64'h8100_0000_0000_0000, 5));
            end

            for (int i = 0; i < dir.size() + 60; i++) begin
                if (i < dir.size()) begin
                    s = dir[i];
                end else begin
                    s.we    = 1'($urandom_range(0, 1));
                    s.f3    = 3'($urandom_range(0, 7));
                    s.addr  = 32'($urandom_range(0, 32'hFFF));
                    if ($urandom_range(0, 3) != 0) s.addr = s.addr & ~((32'd1 << s.f3[1:0]) - 32'd1);
                    s.wd    = {$urandom, $urandom};
                    s.rd    = {$urandom, $urandom};
                    s.delay = int'($urandom_range(0, MW + 1));
                end
                @(negedge clk);
                start = 1'b1; we = s.we; funct3 = s.f3; addr = s.addr;
                wdata = XW'(s.wd); mem_rdata = XW'(s.rd); ack_delay = s.delay;
                sb.push_back(model(s, XW, MW, cyc));
                @(negedge clk);
                start = 1'b0;
                // While busy, poke start with junk; it must be ignored.
                for (int t = 0; t < 100 && sb.size() != 0; t++) begin
                    @(negedge clk);
                    start = (busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (start) begin
                        addr = $urandom; funct3 = 3'($urandom_range(0, 7)); we = 1'($urandom_range(0, 1));
                    end
                end
                start = 1'b0;
                if (sb.size() != 0) begin
                    check(XW, "done_timeout", sb.size(), 0);
                    sb.delete();
                end
            end
            repeat (2) @(negedge clk);
            fin_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && fin_cnt < 2; t++) @(negedge clk);
        if (fin_cnt < 2) check(0, "bench_finish", fin_cnt, 2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
